div: RTL and testbench
======================

# div

Multi-cycle radix-2 restoring divider, the responder side of the execute stage's divide request. The execute stage raises `start` with two 32-bit operands and holds it. This block iterates one quotient bit per cycle and returns `{remainder, quotient}` with `ready`, for the execute stage to forward as HI/LO write data. It also supports cancellation (`annul`) when the requesting instruction is squashed.

## Interface
- Parameters: none. Widths come from the shared macros (`REGS_DATA_BUS` = 32 bits).
- Reset policy: one clock; reset is asynchronous and active-low.
- `clock`  in  1  — rising-edge clock.
- `reset`  in  1  — asynchronous, active-low reset.
- `signed_div`  in  1  — treat operands as two's complement (see Configuration).
- `operand1`  in  32  — dividend; sampled only on request acceptance.
- `operand2`  in  32  — divisor; sampled only on request acceptance.
- `start`  in  1  — request; held high by the requester until it has consumed the result.
- `annul`  in  1  — cancel the in-flight operation.
- `result`  out  64  — `{remainder[63:32], quotient[31:0]}`; registered.
- `ready`  out  1  — result valid; registered.

## Operation
- States: `IDLE`, `BY_ZERO`, `ON`, `END`; 2-bit encoding. Datapath registers:
  - 65-bit working register (upper half = partial remainder, lower half = dividend bits, shifted in quotient bits).
  - 32-bit divisor.
  - 6-bit iteration counter.
- `IDLE`:
  - `start`=1 and `annul`=0 → accept the request.
  - If `operand2`==0, go to `BY_ZERO`.
  - Otherwise load the operand magnitudes, set counter=0 and go to `ON`.
  - `start`=0 or `annul`=1 → stay in `IDLE`.
- `BY_ZERO`: next state `END`; result forced to 0.
- `ON`, per cycle:
  - Compute a 33-bit difference `partial_remainder - {1'b0, divisor}`.
  - Non-negative: partial remainder ← difference, shift in quotient bit 1.
  - Negative: shift in quotient bit 0.
  - Counter increments.
  - When counter==31, the edge completing that iteration applies the sign fix-up, loads `result`, sets `ready`=1 and goes to `END`.
- `END`:
  - Hold `result` and `ready`=1 while `start`=1.
  - `start`=0 → go to `IDLE`, clearing `ready` and `result` to 0.
- Annul:
  - `annul`=1 in `ON` or `BY_ZERO` → go to `IDLE` at the next edge; `ready` stays 0 and `result` stays 0.
  - `annul` in `IDLE` or `END` has no effect.
- `start` dropping during `ON`/`BY_ZERO` is ignored: the operation completes, reaches `END`, then returns to `IDLE` on the next edge because `start`=0.
- A new request is accepted only from `IDLE`; back-to-back requests need `start` low for at least one cycle in `END`.
- Arithmetic: unsigned, quotient = floor(a/b), remainder = a − q·b.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state=`IDLE`, counter=0;
  - working register = 0;
  - `ready`=0, `result`=64'h0.
- Normal divide, `start` accepted at edge N:
  - `ON` during cycles N+1…N+32;
  - `ready`=1 first visible in cycle N+33 (33-cycle latency).
- Divide by zero: `ready`=1 in cycle N+2, `result`=0.
- `ready` falls in the cycle after the first cycle in which `start`=0 is sampled in `END`.
- Reset asserted mid-operation: outputs clear immediately (asynchronous); no partial result is ever presented.
- `result` only changes on entry to/exit from `END`; it is stable for the entire `ready` window.

## Configuration
- `DIV_SIGNED_EN`, defined:
  - When `signed_div`=1, negative operands are negated on load.
  - At completion, the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- `DIV_SIGNED_EN`, undefined:
  - `signed_div` is ignored and all divides are unsigned.
  - Negation/fix-up logic is not synthesized.

## Test plan
- Unsigned divide: `operand1`=100, `operand2`=7, `signed_div`=0, `start` held → `ready` in cycle N+33, `result`=64'h00000002_0000000E.
- Signed divide (with `DIV_SIGNED_EN`): −7 / 2, `signed_div`=1 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Same stimulus without the macro → quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero: `operand2`=0 → `ready`=1 in cycle N+2, `result`=0.
  - Drop `start` → `ready`=0 one cycle later, state `IDLE`.
- Annul: `annul` pulsed in cycle N+10 → `ready` never asserts and `result` stays 0.
  - A new request 2 cycles later completes correctly after 33 cycles.
- Reset mid-operation: `reset`=0 in cycle N+20 → `ready`=0 and `result`=0 immediately.
  - After release, 0xFFFFFFFF / 1 → `result`=64'h00000000_FFFFFFFF.
- Hold/handshake: keep `start`=1 for 5 cycles after `ready` → `result` stable and `ready`=1 throughout; deassert → back to `IDLE`.

Source files
------------

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module   : div
//  Brief    : Multi-cycle radix-2 restoring divider. Accepts a held `start`
//             request, produces one quotient bit per cycle and returns
//             {remainder, quotient} with `ready` until `start` is dropped.
//             `annul` cancels an in-flight divide.
//  Options  : DIV_SIGNED_EN - when defined, `signed_div` selects two's
//             complement operands (magnitude divide plus sign fix-up).
//             When undefined, all divides are unsigned and `signed_div`
//             is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module div (
  input  logic        clock,
  input  logic        reset,
  input  logic        signed_div,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  // Shared data-bus width (REGS_DATA_BUS).
  localparam int         c_data_w    = 32;
  localparam logic [5:0] c_last_iter = 6'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t              r_state;
  // Working register layout: [64:32] shifted partial remainder (the bit at
  // [32] is the next dividend bit already brought down), [31:1] remaining
  // dividend bits followed by quotient bits, [0] free slot for the next
  // quotient bit. Loading the dividend pre-shifted by one keeps every bit
  // of the register in use and lets the compare run straight off [64:32].
  logic [64:0]         r_work;
  logic [c_data_w-1:0] r_divisor;
  logic [5:0]          r_count;

  logic [32:0]         w_diff;
  logic [64:0]         w_work_next;
  logic [c_data_w-1:0] w_quot_raw;
  logic [c_data_w-1:0] w_rem_raw;
  logic [c_data_w-1:0] w_quot_fix;
  logic [c_data_w-1:0] w_rem_fix;
  logic [c_data_w-1:0] w_mag1;
  logic [c_data_w-1:0] w_mag2;

  // One restoring step: trial subtract, keep the difference when it does not
  // borrow, and shift the new quotient bit in at the bottom.
  assign w_diff      = r_work[64:32] - {1'b0, r_divisor};
  assign w_work_next = w_diff[32] ? {r_work[63:0], 1'b0}
                                  : {w_diff[31:0], r_work[31:0], 1'b1};

  // After the last step the remainder sits above the spent padding bit.
  assign w_quot_raw  = w_work_next[31:0];
  assign w_rem_raw   = w_work_next[64:33];

`ifdef DIV_SIGNED_EN
  logic w_op1_neg;
  logic w_op2_neg;
  logic r_neg_quot;
  logic r_neg_rem;

  assign w_op1_neg  = signed_div & operand1[31];
  assign w_op2_neg  = signed_div & operand2[31];

  // Divide magnitudes; 0x80000000 negates to itself, which is its correct
  // unsigned magnitude.
  assign w_mag1     = w_op1_neg ? (~operand1 + 32'd1) : operand1;
  assign w_mag2     = w_op2_neg ? (~operand2 + 32'd1) : operand2;

  // Quotient is negative when the signs differ; remainder follows dividend.
  assign w_quot_fix = r_neg_quot ? (~w_quot_raw + 32'd1) : w_quot_raw;
  assign w_rem_fix  = r_neg_rem  ? (~w_rem_raw  + 32'd1) : w_rem_raw;
`else
  logic w_unused_signed_div;

  assign w_unused_signed_div = signed_div;
  assign w_mag1     = operand1;
  assign w_mag2     = operand2;
  assign w_quot_fix = w_quot_raw;
  assign w_rem_fix  = w_rem_raw;
`endif

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      ready     <= 1'b0;
      result    <= '0;
`ifdef DIV_SIGNED_EN
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !annul) begin
            if (operand2 == '0) begin
              r_state <= BY_ZERO;
            end else begin
              r_work    <= {32'd0, w_mag1, 1'b0};
              r_divisor <= w_mag2;
              r_count   <= '0;
`ifdef DIV_SIGNED_EN
              r_neg_quot <= w_op1_neg ^ w_op2_neg;
              r_neg_rem  <= w_op1_neg;
`endif
              r_state   <= ON;
            end
          end
        end

        BY_ZERO: begin
          if (annul) begin
            r_state <= IDLE;
          end else begin
            r_state <= END;
            ready   <= 1'b1;
            result  <= '0;
          end
        end

        ON: begin
          if (annul) begin
            // Squashed instruction: drop the partial work, never present it.
            r_state <= IDLE;
          end else begin
            r_work  <= w_work_next;
            r_count <= r_count + 6'd1;
            if (r_count == c_last_iter) begin
              result  <= {w_rem_fix, w_quot_fix};
              ready   <= 1'b1;
              r_state <= END;
            end
          end
        end

        END: begin
          // Hold the result for as long as the requester keeps start high.
          if (!start) begin
            r_state <= IDLE;
            ready   <= 1'b0;
            result  <= '0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_div
//  Brief    : Self-checking bench for div. A protocol-level model (latency
//             countdown plus plain / and % arithmetic) is compared against
//             ready/result every falling edge; directed scenarios add
//             hand-computed literal expectations. Honours DIV_SIGNED_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div;

`ifdef DIV_SIGNED_EN
  localparam bit c_signed_build = 1'b1;
`else
  localparam bit c_signed_build = 1'b0;
`endif

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] operand1   = '0;
  logic [31:0] operand2   = '0;
  logic        start      = 1'b0;
  logic        annul      = 1'b0;
  logic [63:0] result;
  logic        ready;

  int tests = 0;
  int fails = 0;

  div dut (
    .clock      (clock),
    .reset      (reset),
    .signed_div (signed_div),
    .operand1   (operand1),
    .operand2   (operand2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {remainder, quotient}; zero divisor gives 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (sgn & c_signed_build) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Protocol model: request accepted in idle, result after 32 edges (1 for
  // divide by zero), held while start stays high, cancelled by annul.
  int          m_busy = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_res  = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_done) begin
      if (!start) begin
        m_done = 1'b0;
        m_res  = '0;
      end
    end else if (m_busy > 0) begin
      if (annul) begin
        m_busy = 0;
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end
    end else if (start && !annul) begin
      m_pend = ref_div(operand1, operand2, signed_div);
      m_busy = (operand2 == 32'd0) ? 1 : 32;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("cyc ready", {63'd0, ready}, {63'd0, m_done});
    check("cyc result", result, m_res);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run one divide from idle; checks latency, result, hold window, release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int exp_lat, input int hold,
                        input string name);
    int cnt = 0;
    operand1   = a;
    operand2   = b;
    signed_div = sgn;
    annul      = 1'b0;
    start      = 1'b1;
    while (cnt < 60 && ready !== 1'b1) begin
      step();
      cnt++;
    end
    check({name, " latency"}, 64'(cnt), 64'(exp_lat));
    check({name, " result"}, result, exp);
    // Operands may change freely once accepted.
    operand1 = $urandom;
    operand2 = $urandom;
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, " hold ready"}, {63'd0, ready}, 64'd1);
      check({name, " hold result"}, result, exp);
    end
    start = 1'b0;
    step();
    check({name, " release ready"}, {63'd0, ready}, 64'd0);
    check({name, " release result"}, result, 64'd0);
  endtask

  initial begin
    int cnt;
    int first;
    int nready;

    // Pin the reference model itself.
    check("model 100/7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    check("model 5/0", ref_div(32'd5, 32'd0, 1'b0), 64'd0);
    check("model ffffffff/1", ref_div(32'hFFFF_FFFF, 32'd1, 1'b0), 64'h00000000_FFFFFFFF);

    // Reset state.
    #1;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("post-reset ready", {63'd0, ready}, 64'd0);

    // Unsigned divides.
    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0, "u100/7");
    do_div(32'd7, 32'd100, 1'b0, 64'h00000007_00000000, 33, 0, "u7/100");
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h00000000_00000001, 33, 0, "umax/max");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 33, 0, "u8000/ffff");

    // Signed request: result depends on build option.
`ifdef DIV_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 0, "s-7/2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 0, "s7/-2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33, 0, "smin/-1");
`else
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC, 33, 0, "s-7/2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000007_00000000, 33, 0, "s7/-2");
`endif

    // Divide by zero, with a short hold.
    do_div(32'd5, 32'd0, 1'b0, 64'd0, 2, 2, "div0");

    // Hold/handshake: start kept high for 5 cycles after ready.
    do_div(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 33, 5, "hold");

    // Annul pulsed in cycle N+10: no result ever appears.
    operand1 = 32'd1000;
    operand2 = 32'd3;
    signed_div = 1'b0;
    start = 1'b1;
    step();
    repeat (9) step();
    annul = 1'b1;
    start = 1'b0;
    step();
    annul = 1'b0;
    nready = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1 || result !== 64'd0) nready++;
      step();
    end
    check("annul no result", 64'(nready), 64'd0);
    do_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33, 0, "after annul");

    // Start dropped mid-operation: completes, ready high for exactly one cycle.
    operand1 = 32'd50;
    operand2 = 32'd6;
    start = 1'b1;
    cnt = 0;
    first = 0;
    nready = 0;
    while (cnt < 45) begin
      step();
      cnt++;
      if (cnt == 3) start = 1'b0;
      if (ready === 1'b1) begin
        nready++;
        if (first == 0) first = cnt;
      end
    end
    check("drop start latency", 64'(first), 64'd33);
    check("drop start ready cycles", 64'(nready), 64'd1);

    // Reset asserted mid-operation (cycle N+20).
    operand1 = 32'hFFFF_FFFF;
    operand2 = 32'd3;
    start = 1'b1;
    step();
    repeat (19) step();
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("mid reset ready", {63'd0, ready}, 64'd0);
    check("mid reset result", result, 64'd0);
    step();
    reset = 1'b1;
    step();
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 0, "after reset");

    // Reset while a result is presented clears outputs without a clock edge.
    operand1 = 32'd100;
    operand2 = 32'd7;
    start = 1'b1;
    cnt = 0;
    while (cnt < 60 && ready !== 1'b1) begin
      step();
      cnt++;
    end
    check("end-state ready before reset", {63'd0, ready}, 64'd1);
    #2;
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("async reset ready", {63'd0, ready}, 64'd0);
    check("async reset result", result, 64'd0);
    step();
    reset = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
